// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn controller and its line checker.
package ttt_pkg;

  localparam int BOARD_W = 18;
  localparam int CELL_N  = 9;

  localparam logic [1:0] RES_PLAYING = 2'b00;
  localparam logic [1:0] RES_X_WIN   = 2'b01;
  localparam logic [1:0] RES_O_WIN   = 2'b10;
  localparam logic [1:0] RES_DRAW    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_CHECK,
    ST_WRITE,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Cell k (1..9) sits at bits [2(9-k)+1 : 2(9-k)]; the upper bit is O.
  function automatic logic [4:0] cell_bit(input logic [3:0] k, input logic is_o);
    logic [4:0] base;
    base = 5'd18 - {k, 1'b0};
    return base + {4'd0, is_o};
  endfunction

endpackage

// File: rtl/ttt_turn_ctrl_if.sv
// Keypad/menu inputs and board/status outputs of the turn controller.
interface ttt_turn_ctrl_if;
  import ttt_pkg::*;

  logic               start;
  logic               key_valid;
  logic [3:0]         key_data;
  logic [BOARD_W-1:0] board;
  logic               turn_o;
  logic [1:0]         result;
  logic               game_over;
  logic               busy;
  logic               invalid_move;
  logic               timeout;

  modport master (
    output start, key_valid, key_data,
    input  board, turn_o, result, game_over, busy, invalid_move, timeout
  );

  modport slave (
    input  start, key_valid, key_data,
    output board, turn_o, result, game_over, busy, invalid_move, timeout
  );
endinterface

// File: rtl/ttt_line_check.sv
// Combinational win/full detector for one player's marks on the packed board.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic               player,
  output logic               win,
  output logic               full
);

  logic [CELL_N-1:0] mark;
  logic [CELL_N-1:0] occ;

  always_comb begin
    mark = '0;
    occ  = '0;
    for (int k = 1; k <= CELL_N; k++) begin
      mark[k-1] = board[cell_bit(4'(k), player)];
      occ[k-1]  = board[cell_bit(4'(k), 1'b0)] | board[cell_bit(4'(k), 1'b1)];
    end
  end

  // mark[k-1] is cell k: rows, columns, then the two diagonals.
  assign win = (mark[0] & mark[1] & mark[2]) |
               (mark[3] & mark[4] & mark[5]) |
               (mark[6] & mark[7] & mark[8]) |
               (mark[0] & mark[3] & mark[6]) |
               (mark[1] & mark[4] & mark[7]) |
               (mark[2] & mark[5] & mark[8]) |
               (mark[0] & mark[4] & mark[8]) |
               (mark[2] & mark[4] & mark[6]);

  assign full = &occ;

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe move sequencer: sole writer of the board, tracks turn and result.
//   state    | meaning
//   IDLE     | no game, waiting for start
//   WAIT_KEY | waiting for the current player's key; turn timer runs
//   CHECK    | latched cell tested for occupancy
//   WRITE    | mover's mark written into the board
//   EVAL     | win/draw evaluated on the registered board
//   DONE     | game over, outputs frozen until start
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int TURN_TIMEOUT = 0,
  parameter int CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst,
  ttt_turn_ctrl_if.slave bus
);

  localparam bit               TO_EN   = (TURN_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

  state_t             state;
  logic [3:0]         cell_q;
  logic [CNT_W-1:0]   cnt;
  logic [BOARD_W-1:0] board_q;
  logic               turn_q;
  logic [1:0]         result_q;
  logic               game_over_q;
  logic               busy_q;
  logic               invalid_q;
  logic               timeout_q;
  logic               win;
  logic               full;
  logic               key_ok;
  logic               occupied;

  assign key_ok   = bus.key_valid && (bus.key_data >= 4'd1) && (bus.key_data <= 4'd9);
  assign occupied = board_q[cell_bit(cell_q, 1'b0)] | board_q[cell_bit(cell_q, 1'b1)];

  ttt_line_check u_line_check (
    .board  (board_q),
    .player (turn_q),
    .win    (win),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cell_q      <= '0;
      cnt         <= '0;
      board_q     <= '0;
      turn_q      <= 1'b0;
      result_q    <= RES_PLAYING;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      invalid_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            board_q     <= '0;
            turn_q      <= 1'b0;
            result_q    <= RES_PLAYING;
            cnt         <= '0;
            game_over_q <= 1'b0;
            state       <= ST_WAIT_KEY;
          end
        end
        ST_WAIT_KEY: begin
          if (bus.start) begin
            board_q <= '0;
            turn_q  <= 1'b0;
            cnt     <= '0;
          end else if (key_ok) begin
            cell_q <= bus.key_data;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_CHECK;
          end else if (TO_EN && (cnt == TO_LAST)) begin
            timeout_q <= 1'b1;
            turn_q    <= ~turn_q;
            cnt       <= '0;
          end else if (TO_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (occupied) begin
            invalid_q <= 1'b1;
            busy_q    <= 1'b0;
            cnt       <= '0;
            state     <= ST_WAIT_KEY;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          board_q[cell_bit(cell_q, turn_q)] <= 1'b1;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          busy_q <= 1'b0;
          if (win) begin
            result_q    <= turn_q ? RES_O_WIN : RES_X_WIN;
            game_over_q <= 1'b1;
            state       <= ST_DONE;
          end else if (full) begin
            result_q    <= RES_DRAW;
            game_over_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            turn_q <= ~turn_q;
            cnt    <= '0;
            state  <= ST_WAIT_KEY;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          game_over_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.board        = board_q;
  assign bus.turn_o       = turn_q;
  assign bus.result       = result_q;
  assign bus.game_over    = game_over_q;
  assign bus.busy         = busy_q;
  assign bus.invalid_move = invalid_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Randomized and directed bench for ttt_turn_ctrl against a cell-array game model.
module tb_ttt_turn_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ttt_turn_ctrl_if bus ();
  ttt_turn_ctrl_if tbus ();

  ttt_turn_ctrl #(.TURN_TIMEOUT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ttt_turn_ctrl #(.TURN_TIMEOUT(8), .CNT_W(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (tbus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int to_seen  = 0;

  // Model: cells[k] is 0 empty, 1 X, 2 O.
  int         cells [1:9];
  bit         m_turn;
  logic [1:0] m_res;
  bit         m_active;
  bit         m_done;
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  function automatic bit model_wins(int p);
    for (int l = 0; l < 8; l++)
      if (cells[lines[l][0]] == p && cells[lines[l][1]] == p && cells[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int k = 1; k <= 9; k++) if (cells[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int k = 1; k <= 9; k++) begin
      if (cells[k] == 1) b[2*(9-k)]   = 1'b1;
      if (cells[k] == 2) b[2*(9-k)+1] = 1'b1;
    end
    return b;
  endfunction

  task automatic model_clear(bit active);
    for (int k = 1; k <= 9; k++) cells[k] = 0;
    m_turn = 0; m_res = 2'b00; m_active = active; m_done = 0;
  endtask

  task automatic check_state(string tag);
    n_checks++;
    if (bus.board !== model_board()) $display("FAIL %s board got %b exp %b", tag, bus.board, model_board());
    else n_pass++;
    n_checks++;
    if (bus.turn_o !== m_turn) $display("FAIL %s turn_o got %b exp %b", tag, bus.turn_o, m_turn);
    else n_pass++;
    n_checks++;
    if (bus.result !== m_res) $display("FAIL %s result got %b exp %b", tag, bus.result, m_res);
    else n_pass++;
    n_checks++;
    if (bus.game_over !== m_done) $display("FAIL %s game_over got %b exp %b", tag, bus.game_over, m_done);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy_idle got %b exp 0", tag, bus.busy);
    else n_pass++;
  endtask

  task automatic start_game();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_clear(1'b0);
  endtask

  task automatic play_key(input int k, input string tag);
    bit acc;
    int exp_inv;
    int inv_seen;
    acc = m_active && k >= 1 && k <= 9;
    exp_inv = 0;
    if (acc) begin
      if (cells[k] != 0) exp_inv = 1;
      else begin
        cells[k] = m_turn ? 2 : 1;
        if (model_wins(cells[k])) begin
          m_res = m_turn ? 2'b10 : 2'b01; m_done = 1; m_active = 0;
        end else if (model_full()) begin
          m_res = 2'b11; m_done = 1; m_active = 0;
        end else m_turn = ~m_turn;
      end
    end
    @(negedge clk); bus.key_valid = 1'b1; bus.key_data = 4'(k);
    @(negedge clk); bus.key_valid = 1'b0;
    n_checks++;
    if (bus.busy !== acc) $display("FAIL %s busy got %b exp %b", tag, bus.busy, acc);
    else n_pass++;
    inv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.invalid_move) inv_seen++;
      if (bus.timeout) to_seen++;
    end
    n_checks++;
    if (inv_seen !== exp_inv) $display("FAIL %s invalid_pulses got %0d exp %0d", tag, inv_seen, exp_inv);
    else n_pass++;
    check_state(tag);
  endtask

  task automatic play_seq(input int seq[], input string tag);
    foreach (seq[i]) play_key(seq[i], tag);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear(1'b0);
    check_state("reset");
    n_checks++;
    if (tbus.board !== 18'd0 || tbus.turn_o !== 1'b0 || tbus.timeout !== 1'b0)
      $display("FAIL reset_to board %b turn %b timeout %b exp 0", tbus.board, tbus.turn_o, tbus.timeout);
    else n_pass++;
    play_key(5, "idle_key");
  endtask

  task automatic test_reset_mid_game();
    start_game();
    play_seq('{1, 5, 9}, "pre_rst");
    do_reset();
    check_state("mid_rst");
    play_key(3, "post_rst_key");
    start_game();
    play_key(3, "post_rst_start");
  endtask

  task automatic test_row_win();
    start_game();
    play_seq('{1, 4, 2, 5, 3}, "row_win");
    n_checks++;
    if (bus.board !== 18'b01_01_01_10_10_00_00_00_00 || bus.result !== 2'b01)
      $display("FAIL row_win_const board %b result %b exp %b 01", bus.board, bus.result,
               18'b01_01_01_10_10_00_00_00_00);
    else n_pass++;
    play_key(6, "done_key");
  endtask

  task automatic test_occupied();
    start_game();
    play_key(5, "occ_first");
    play_key(5, "occ_second");
    n_checks++;
    if (bus.board[9] !== 1'b0 || bus.turn_o !== 1'b1)
      $display("FAIL occ_const bit9 %b turn %b exp 0 1", bus.board[9], bus.turn_o);
    else n_pass++;
  endtask

  task automatic test_draw();
    start_game();
    play_seq('{1, 2, 3, 5, 4, 6, 8, 7, 9}, "draw");
    n_checks++;
    if (bus.result !== 2'b11 || bus.turn_o !== 1'b0)
      $display("FAIL draw_const result %b turn %b exp 11 0", bus.result, bus.turn_o);
    else n_pass++;
    start_game();
    play_seq('{1, 3, 2, 8, 5, 4, 6, 7, 9}, "ninth_win");
    n_checks++;
    if (bus.result !== 2'b01) $display("FAIL ninth_win_const result %b exp 01", bus.result);
    else n_pass++;
  endtask

  task automatic test_ignored();
    start_game();
    play_key(0, "key0");
    play_key(12, "key12");
    cells[1] = 1; m_turn = 1;
    @(negedge clk); bus.key_valid = 1'b1; bus.key_data = 4'd1;
    @(negedge clk); bus.key_data = 4'd2;
    @(negedge clk); bus.key_data = 4'd3;
    @(negedge clk); bus.key_data = 4'd4;
    @(negedge clk); bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_state("busy_keys");
  endtask

  task automatic test_timeout();
    int first_to;
    int extra;
    @(negedge clk); tbus.start = 1'b1;
    @(negedge clk); tbus.start = 1'b0;
    first_to = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (tbus.timeout && first_to < 0) first_to = i;
    end
    n_checks++;
    if (first_to !== 8) $display("FAIL to_delay got %0d exp 8", first_to);
    else n_pass++;
    n_checks++;
    if (tbus.turn_o !== 1'b1) $display("FAIL to_turn got %b exp 1", tbus.turn_o);
    else n_pass++;
    extra = 0;
    repeat (7) begin
      @(negedge clk);
      if (tbus.timeout) extra++;
    end
    tbus.key_valid = 1'b1; tbus.key_data = 4'd5;
    @(negedge clk); tbus.key_valid = 1'b0;
    n_checks++;
    if (tbus.busy !== 1'b1) $display("FAIL to_key_taken busy got %b exp 1", tbus.busy);
    else n_pass++;
    if (tbus.timeout) extra++;
    repeat (4) begin
      @(negedge clk);
      if (tbus.timeout) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL to_key_wins pulses got %0d exp 0", extra);
    else n_pass++;
    n_checks++;
    if (tbus.board !== (18'd1 << 9) || tbus.turn_o !== 1'b0)
      $display("FAIL to_move board %b turn %b exp %b 0", tbus.board, tbus.turn_o, 18'd1 << 9);
    else n_pass++;
  endtask

  task automatic test_random();
    int k;
    for (int g = 0; g < 20; g++) begin
      start_game();
      for (int m = 0; m < 25 && !m_done; m++) begin
        if ($urandom_range(0, 29) == 0) start_game();
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
        play_key(k, "random");
      end
    end
    n_checks++;
    if (to_seen !== 0) $display("FAIL no_timeout pulses got %0d exp 0", to_seen);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_data = 4'd0;
    tbus.start = 1'b0; tbus.key_valid = 1'b0; tbus.key_data = 4'd0;
    test_reset();
    test_row_win();
    test_occupied();
    test_draw();
    test_ignored();
    test_reset_mid_game();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ttt_turn_ctrl.md
Name: ttt_turn_ctrl

Overview:
Sequencing controller for the tic-tac-toe board datapath. It accepts keypad move strobes and checks that the target cell is empty. It then writes the current player's mark into the 18-bit board register, evaluates win/draw, and advances the turn. The display and dot-matrix modules consume its board, turn and result outputs. It is the only writer of the board.

Parameters:
TURN_TIMEOUT, 0, clk cycles allowed per turn before the turn is forfeited; 0 disables the timeout.
CNT_W, 32, width of the timeout counter; must satisfy 2^CNT_W > TURN_TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse from main menu; starts a new game from IDLE or DONE
key_valid  in  1  one-cycle strobe; key_data is valid in the same cycle
key_data  in  4  cell number 1..9 (row-major, top-left = 1); 0 and 10..15 are ignored
board  out  18  cell k occupies bits [2(9-k)+1 : 2(9-k)]; upper bit = O, lower bit = X
turn_o  out  1  0 = X to move (P1), 1 = O to move (P2)
result  out  2  00 in progress, 01 X wins, 10 O wins, 11 draw
game_over  out  1  high while in DONE
busy  out  1  high in CHECK, WRITE, EVAL
invalid_move  out  1  one-cycle pulse when a move targets an occupied cell
timeout  out  1  one-cycle pulse when a turn is forfeited

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE; board = 0; turn_o = 0; result = 00.
  - game_over, busy, invalid_move, timeout = 0; timeout counter = 0.
  - rst overrides every other input in that cycle, including a mid-move or DONE state.
- FSM states: IDLE, WAIT_KEY, CHECK, WRITE, EVAL, DONE.
- IDLE:
  - start -> WAIT_KEY; board cleared, turn_o = 0, result = 00.
  - key_valid is ignored.
- WAIT_KEY:
  - key_valid with key_data in 1..9 latches the cell index -> CHECK.
  - Out-of-range keys are dropped silently; state stays WAIT_KEY.
  - A start pulse in WAIT_KEY restarts the game: board cleared, turn_o = 0.
- CHECK (1 cycle):
  - Cell occupied (either bit set) -> invalid_move = 1 for one cycle, back to WAIT_KEY; turn unchanged.
  - Cell empty -> WRITE.
- WRITE (1 cycle):
  - Set bit 2(9-k)+turn_o of board.
  - Board reflects the move 2 cycles after the key_valid edge.
- EVAL (1 cycle): the line checker operates on the registered board.
  - Current mover has any of the 8 lines (3 rows, 3 columns, 2 diagonals) -> result = 01 if turn_o = 0, 10 if turn_o = 1; -> DONE.
  - Otherwise, all 9 cells occupied -> result = 11; -> DONE.
  - Otherwise -> turn_o toggles; -> WAIT_KEY.
  - A win takes precedence over a draw on the ninth move.
- DONE:
  - game_over = 1; board, result and turn_o are frozen.
  - Keys are ignored; start -> new game as from IDLE.
- key_valid while busy is ignored; there is no queueing.
- Timeout (only when TURN_TIMEOUT > 0):
  - The counter runs only in WAIT_KEY and clears on entry to WAIT_KEY.
  - When the count reaches TURN_TIMEOUT-1: timeout pulses, turn_o toggles, counter clears, state stays WAIT_KEY.
  - If key_valid with a valid key arrives in the same cycle as expiry, the key wins; no timeout.
- result stays 00 in every state except DONE. Outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package ttt_pkg:
  - result codes RES_PLAYING = 2'b00, RES_X_WIN = 2'b01, RES_O_WIN = 2'b10, RES_DRAW = 2'b11.
  - FSM state encoding; board width 18; cell count 9.
  - function cell_bit(k, is_o) returning 2(9-k)+is_o.
- Sub-module ttt_line_check (combinational):
  - inputs board[17:0] and player select.
  - outputs win and full.
  - reused by any future AI or replay block.

Test Plan:
- Reset mid-game: 3 moves, then rst for 1 cycle -> board = 0, turn_o = 0, result = 00, state IDLE; keys ignored until start.
- X row win: start; keys 1,4,2,5,3 -> board = 18'b01_01_01_10_10_00_00_00_00, result = 01, game_over = 1; key 6 afterwards leaves board unchanged.
- Occupied cell: start; key 5, then key 5 -> invalid_move pulses exactly once, board bit 9 stays 0, turn_o remains 1.
- Draw: keys 1,2,3,5,4,6,8,7,9 -> result = 11, and turn_o = 0 at DONE. Separately, a sequence where the 9th move completes a line -> win code, not 11.
- Timeout with TURN_TIMEOUT = 8: start, no keys -> timeout pulses 8 cycles after entering WAIT_KEY, turn_o toggles. Key arriving on the expiry cycle -> no timeout pulse and the move is taken.
- Ignored inputs: key_data 0 and 12 in WAIT_KEY, and a key_valid during CHECK/WRITE/EVAL -> board, turn_o and state unaffected.
